i2c_codec_target: RTL and testbench
===================================

I2C_CODEC_TARGET -- requirements
Module: i2c_codec_target

Interface
REQ-001 SHALL provide parameter DEV_ADDR, default 7'h1A, 7-bit I2C device address the block answers to.
REQ-002 SHALL provide parameter NUM_REGS, default 16, number of implemented 9-bit registers (1..128).
REQ-003 SHALL provide parameter SYNC_STAGES, default 2, synchroniser depth on scl_i/sda_i (>=2).
REQ-004 SHALL provide port board_clk, input, 1, sole clock; single clock domain; reset is synchronous and active-high.
REQ-005 SHALL provide port reset, input, 1, synchronous active-high reset sampled on board_clk rising edge.
REQ-006 SHALL provide port scl_i, input, 1, asynchronous bus SCL level.
REQ-007 SHALL provide port sda_i, input, 1, asynchronous bus SDA level.
REQ-008 SHALL provide port sda_oe, output, 1, 1 = pull SDA low (open-drain enable); 0 = release.
REQ-009 SHALL provide port wr_valid, output, 1, one-cycle pulse per committed register write.
REQ-010 SHALL provide ports wr_addr (output, 7) and wr_data (output, 9), address/data of the write, valid with wr_valid.
REQ-011 SHALL provide ports rd_addr (input, 7) and rd_data (output, 9), combinational register peek; 0 if rd_addr >= NUM_REGS.
REQ-012 SHALL provide ports busy (output, 1, high from START to STOP) and oob_err (output, 1, one-cycle pulse on out-of-range write).

Function
REQ-013 SHALL synchronise scl_i/sda_i through SYNC_STAGES flops and detect edges on the synchronised values only.
REQ-014 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high; both valid in any state.
REQ-015 SHALL use states IDLE, DEV, DEV_ACK, B1, B1_ACK, B2, B2_ACK, IGNORE (plus RD, RD_ACK per REQ-027).
REQ-016 SHALL sample data bits MSB first on synchronised SCL rising edge; bit counter 0..7 per byte.
REQ-017 START (incl. repeated START) -> DEV, bit counter cleared; STOP -> IDLE, sda_oe = 0.
REQ-018 DEV: after 8th bit, address match with R/W=0 -> DEV_ACK; mismatch -> IGNORE (no ACK).
REQ-019 ACK phases: sda_oe SHALL assert on the SCL falling edge ending the 8th bit and deassert on the next SCL falling edge.
REQ-020 B1 byte SHALL latch {reg_addr[6:0], data[8]}; B2 byte SHALL latch data[7:0]; both bytes ACKed.
REQ-021 On 8th bit of B2 sampled, if reg_addr < NUM_REGS: register updated and wr_valid pulsed exactly one cycle later; else register file unchanged, oob_err pulsed instead, byte still ACKed.
REQ-022 After B2_ACK SHALL return to B1, accepting further address/data pairs until STOP or START.
REQ-023 STOP or START arriving mid-byte SHALL discard the partial pair; no wr_valid.
REQ-024 IGNORE SHALL never drive sda_oe and exits only on START/STOP.

Reset
REQ-025 Reset SHALL force: state IDLE, sda_oe 0, wr_valid 0, oob_err 0, busy 0, wr_addr 0, wr_data 0, all registers 9'h000, synchroniser flops to 1 (bus idle).
REQ-026 Reset asserted mid-transaction SHALL abort it without write; after release block SHALL wait for next START (IDLE ignores data bits).

Configuration
REQ-027 With macro I2C_TARGET_READ_EN defined: DEV match with R/W=1 SHALL ACK and enter RD, shifting out {last_reg_addr, data[8]} then data[7:0] on SCL falling edges; master ACK -> next byte (alternating pair); master NACK -> IGNORE until STOP. last_reg_addr = address of the most recent B1, 0 after reset.
REQ-028 Without I2C_TARGET_READ_EN: R/W=1 SHALL be treated as mismatch (NACK, IGNORE); RD/RD_ACK states not built.

Verification
REQ-029 Write: START, 0x34, 0x0C, 0x10, STOP -> three ACKs, wr_valid once with wr_addr 0x06, wr_data 0x010; rd_addr 6 -> rd_data 0x010.
REQ-030 Wrong address: START, 0x36, 0x0C, 0x10, STOP -> sda_oe never 1, no wr_valid, registers unchanged.
REQ-031 Out of range (NUM_REGS=16): START, 0x34, 0x23, 0xFF, STOP -> ACKs given, oob_err pulse, no wr_valid; rd_addr 0x11 -> 0.
REQ-032 Burst: START, 0x34, 0x02, 0x55, 0x05, 0xAA, STOP -> wr_valid twice: (0x01,0x055) then (0x02,0x1AA).
REQ-033 Abort: reset pulse after 4 bits of byte 0x0C, then full write 0x34,0x0E,0x01 -> only (0x07,0x001) written, sda_oe 0 during reset.
REQ-034 With I2C_TARGET_READ_EN after REQ-029: START,0x34,0x0C, Sr,0x35, read 2 bytes (ACK, NACK), STOP -> bytes 0x0C, 0x10 returned.

Source files
------------

// File: rtl/i2c_codec_target.sv
// I2C target exposing a 9-bit codec register file written as {addr[6:0],d[8]},{d[7:0]} byte pairs.
// Define I2C_TARGET_READ_EN to build the optional read-back path (RD/RD_ACK states).
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       busy,
    output logic       oob_err
);

    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);
`ifdef I2C_TARGET_READ_EN
    localparam bit         READ_EN    = 1'b1;
`else
    localparam bit         READ_EN    = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, B1, B1_ACK, B2, B2_ACK, IGNORE
`ifdef I2C_TARGET_READ_EN
        , RD, RD_ACK
`endif
    } state_t;

    // Synchronisers reset to 1 so a reset looks like an idle bus, never a START.
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;

    always_ff @(posedge board_clk) begin
        if (reset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
            scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
            sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       sda_oe_reg;
    logic       wr_valid_reg;
    logic       oob_err_reg;
    logic       busy_reg;
    logic [6:0] wr_addr_reg;
    logic [8:0] wr_data_reg;
    logic [6:0] reg_addr_reg;
    logic       d8_reg;

    logic [7:0] rx_byte;
    logic       last_bit;
    logic       dev_match;
    logic       addr_in_range;
    logic       commit;
    logic [8:0] commit_data;

    // The eighth bit is not yet in shift_reg when it is sampled, so splice it in.
    assign rx_byte       = {shift_reg[6:0], sda_s};
    assign last_bit      = scl_rise & (bit_cnt_reg == 3'd7);
    assign dev_match     = (rx_byte[7:1] == DEV_ADDR) && (!rx_byte[0] || READ_EN);
    assign addr_in_range = ({1'b0, reg_addr_reg} < NUM_REGS_W);
    assign commit        = (state_reg == B2) && last_bit && addr_in_range;
    assign commit_data   = {d8_reg, rx_byte};

    logic [8:0] regs_reg [NUM_REGS];

    always_ff @(posedge board_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit) begin
            regs_reg[reg_addr_reg[AW-1:0]] <= commit_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < NUM_REGS_W) begin
            rd_data = regs_reg[rd_addr[AW-1:0]];
        end
    end

`ifdef I2C_TARGET_READ_EN
    logic       rw_reg;
    logic       byte_sel_reg;
    logic [7:0] tx_reg;
    logic [8:0] peek_data;
    logic [7:0] tx_next;

    // Read-back always targets the address of the most recent B1 byte.
    always_comb begin
        peek_data = '0;
        if (addr_in_range) begin
            peek_data = regs_reg[reg_addr_reg[AW-1:0]];
        end
        tx_next = byte_sel_reg ? peek_data[7:0] : {reg_addr_reg, peek_data[8]};
    end
`endif

    always_ff @(posedge board_clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            sda_oe_reg   <= 1'b0;
            wr_valid_reg <= 1'b0;
            oob_err_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            reg_addr_reg <= '0;
            d8_reg       <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            rw_reg       <= 1'b0;
            byte_sel_reg <= 1'b0;
            tx_reg       <= '0;
`endif
        end else begin
            wr_valid_reg <= 1'b0;
            oob_err_reg  <= 1'b0;
            if (start_det) begin
                state_reg   <= DEV;
                bit_cnt_reg <= '0;
                sda_oe_reg  <= 1'b0;
                busy_reg    <= 1'b1;
            end else if (stop_det) begin
                state_reg   <= IDLE;
                bit_cnt_reg <= '0;
                sda_oe_reg  <= 1'b0;
                busy_reg    <= 1'b0;
            end else begin
                if (scl_rise) begin
                    shift_reg <= rx_byte;
                end
                case (state_reg)
                    DEV: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg <= dev_match ? DEV_ACK : IGNORE;
`ifdef I2C_TARGET_READ_EN
                                rw_reg    <= rx_byte[0];
`endif
                            end
                        end
                    end
                    // ACK states: first SCL fall pulls SDA low, second fall releases it.
                    DEV_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_reg) begin
                                sda_oe_reg <= 1'b1;
                            end else begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= B1;
`ifdef I2C_TARGET_READ_EN
                                if (rw_reg) begin
                                    state_reg    <= RD;
                                    bit_cnt_reg  <= '0;
                                    byte_sel_reg <= 1'b1;
                                    tx_reg       <= {reg_addr_reg, peek_data[8]} << 1;
                                    sda_oe_reg   <= ~reg_addr_reg[6];
                                end
`endif
                            end
                        end
                    end
                    B1: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                reg_addr_reg <= rx_byte[7:1];
                                d8_reg       <= rx_byte[0];
                                state_reg    <= B1_ACK;
                            end
                        end
                    end
                    B1_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_reg) begin
                                sda_oe_reg <= 1'b1;
                            end else begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= B2;
                            end
                        end
                    end
                    B2: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg <= B2_ACK;
                                if (addr_in_range) begin
                                    wr_valid_reg <= 1'b1;
                                    wr_addr_reg  <= reg_addr_reg;
                                    wr_data_reg  <= commit_data;
                                end else begin
                                    oob_err_reg  <= 1'b1;
                                end
                            end
                        end
                    end
                    B2_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_reg) begin
                                sda_oe_reg <= 1'b1;
                            end else begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= B1;
                            end
                        end
                    end
`ifdef I2C_TARGET_READ_EN
                    // Each SCL fall presents the next bit; after the eighth, release for the master ACK.
                    RD: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 3'd7) begin
                                sda_oe_reg  <= 1'b0;
                                bit_cnt_reg <= '0;
                                state_reg   <= RD_ACK;
                            end else begin
                                sda_oe_reg  <= ~tx_reg[7];
                                tx_reg      <= tx_reg << 1;
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise && sda_s) begin
                            state_reg <= IGNORE;
                        end else if (scl_fall) begin
                            state_reg    <= RD;
                            bit_cnt_reg  <= '0;
                            byte_sel_reg <= ~byte_sel_reg;
                            tx_reg       <= tx_next << 1;
                            sda_oe_reg   <= ~tx_next[7];
                        end
                    end
`endif
                    IDLE, IGNORE: begin
                        sda_oe_reg <= 1'b0;
                    end
                    default: begin
                        state_reg  <= IDLE;
                        sda_oe_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_reg;
    assign wr_valid = wr_valid_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign busy     = busy_reg;
    assign oob_err  = oob_err_reg;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Scoreboard bench for i2c_codec_target: bit-banged I2C master, write events checked by a monitor.
module tb_i2c_codec_target;

    localparam int Q = 6;

    logic       board_clk  = 1'b0;
    logic       reset      = 1'b1;
    logic       master_scl = 1'b1;
    logic       master_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [6:0] rd_addr = '0;
    logic [8:0] rd_data;
    logic       busy;
    logic       oob_err;

    assign sda_bus = master_sda & ~sda_oe;

    i2c_codec_target #(
        .DEV_ADDR   (7'h1A),
        .NUM_REGS   (16),
        .SYNC_STAGES(2)
    ) dut (
        .board_clk(board_clk),
        .reset    (reset),
        .scl_i    (master_scl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .oob_err  (oob_err)
    );

    always #5 board_clk = ~board_clk;

    typedef struct packed {
        logic       oob;
        logic [6:0] addr;
        logic [8:0] data;
    } exp_t;
    typedef logic [7:0] bytes_t [6];

    exp_t exp_q[$];
    exp_t sb_e;
    int   checks    = 0;
    int   errors    = 0;
    int   oe_cycles = 0;

    // Monitor: every wr_valid / oob_err pulse must match the head of the expectation queue.
    always @(negedge board_clk) begin
        if (sda_oe) oe_cycles++;
        if (!reset && (wr_valid || oob_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got wr_valid=%0b oob_err=%0b addr=0x%0h data=0x%0h, expected no event",
                         wr_valid, oob_err, wr_addr, wr_data);
            end else begin
                sb_e = exp_q.pop_front();
                if (sb_e.oob) begin
                    if (!oob_err || wr_valid) begin
                        errors++;
                        $display("FAIL sb_oob: got wr_valid=%0b oob_err=%0b, expected oob_err only",
                                 wr_valid, oob_err);
                    end
                end else if (!wr_valid || oob_err || wr_addr !== sb_e.addr || wr_data !== sb_e.data) begin
                    errors++;
                    $display("FAIL sb_write: got valid=%0b oob=%0b addr=0x%0h data=0x%0h, expected addr=0x%0h data=0x%0h",
                             wr_valid, oob_err, wr_addr, wr_data, sb_e.addr, sb_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge board_clk);
        #1;
    endtask

    task automatic i2c_start();
        master_sda = 1'b1; wait_q();
        master_scl = 1'b1; wait_q();
        master_sda = 1'b0; wait_q();
        master_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        master_sda = 1'b0; wait_q();
        master_scl = 1'b1; wait_q();
        master_sda = 1'b1; wait_q();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        master_sda = b;    wait_q();
        master_scl = 1'b1; wait_q();
        s = sda_bus;       wait_q();
        master_scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] v, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(v[i], s);
        clock_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            v[i] = s;
        end
        clock_bit(~ack, s);
    endtask

    task automatic peek(input string name, input logic [6:0] a, input logic [8:0] exp);
        rd_addr = a;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic write_seq(input string name, input bytes_t b, input int n, input logic exp_ack);
        logic a;
        i2c_start();
        check({name, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            send_byte(b[i], a);
            check($sformatf("%s_ack%0d", name, i), 32'(a), 32'(exp_ack));
        end
        i2c_stop();
        wait_q();
        check({name, "_idle"}, 32'(busy), 32'd0);
        $display("txn %s: %0d bytes", name, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    logic       ack;
    logic [7:0] rx;
    int         oe_before;

    initial begin
        reset = 1'b1;
        repeat (4) @(posedge board_clk);
        #1;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_oob_err", 32'(oob_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;
        wait_q();
        peek("rst_reg6", 7'd6, 9'h000);

        // Single write: 0x0C -> addr 6, d8 0; 0x10 -> data 0x010
        exp_q.push_back('{oob: 1'b0, addr: 7'h06, data: 9'h010});
        write_seq("write", '{8'h34, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00}, 3, 1'b1);
        peek("write_rd6", 7'd6, 9'h010);

        // Wrong device address 0x1B: no ACK, no write, SDA never driven
        oe_before = oe_cycles;
        write_seq("wrong_addr", '{8'h36, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00}, 3, 1'b0);
        check("wrong_addr_oe", 32'(oe_cycles - oe_before), 32'd0);
        peek("wrong_addr_rd6", 7'd6, 9'h010);

        // Out of range: 0x23 -> addr 0x11
        exp_q.push_back('{oob: 1'b1, addr: 7'h00, data: 9'h000});
        write_seq("oob", '{8'h34, 8'h23, 8'hFF, 8'h00, 8'h00, 8'h00}, 3, 1'b1);
        peek("oob_rd11", 7'h11, 9'h000);
        peek("oob_rd1", 7'h01, 9'h000);

        // Burst of two pairs
        exp_q.push_back('{oob: 1'b0, addr: 7'h01, data: 9'h055});
        exp_q.push_back('{oob: 1'b0, addr: 7'h02, data: 9'h1AA});
        write_seq("burst", '{8'h34, 8'h02, 8'h55, 8'h05, 8'hAA, 8'h00}, 5, 1'b1);
        peek("burst_rd1", 7'd1, 9'h055);
        peek("burst_rd2", 7'd2, 9'h1AA);

        // Set pointer to reg 6, repeated START, then read address
        i2c_start();
        send_byte(8'h34, ack);
        check("rd_dev_ack", 32'(ack), 32'd1);
        send_byte(8'h0C, ack);
        check("rd_ptr_ack", 32'(ack), 32'd1);
        i2c_start();
        send_byte(8'h35, ack);
`ifdef I2C_TARGET_READ_EN
        check("rd_rdev_ack", 32'(ack), 32'd1);
        recv_byte(1'b1, rx);
        check("rd_byte0", 32'(rx), 32'h0C);
        recv_byte(1'b0, rx);
        check("rd_byte1", 32'(rx), 32'h10);
`else
        check("rd_rdev_nack", 32'(ack), 32'd0);
`endif
        i2c_stop();
        wait_q();
        check("rd_idle", 32'(busy), 32'd0);
        peek("rd_rd6", 7'd6, 9'h010);
        $display("txn read_back: pointer 0x0C");

        // Reset after 4 bits of 0x0C aborts the pair
        i2c_start();
        send_byte(8'h34, ack);
        check("abort_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, ack);
        reset = 1'b1;
        repeat (2) @(posedge board_clk);
        #1;
        check("abort_oe_rst", 32'(sda_oe), 32'd0);
        check("abort_busy_rst", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_q();
        $display("txn abort: reset mid-byte");
        exp_q.push_back('{oob: 1'b0, addr: 7'h07, data: 9'h001});
        write_seq("post_reset", '{8'h34, 8'h0E, 8'h01, 8'h00, 8'h00, 8'h00}, 3, 1'b1);
        peek("post_reset_rd7", 7'd7, 9'h001);
        peek("post_reset_rd6", 7'd6, 9'h000);

        repeat (20) @(posedge board_clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
